// File: rtl/cozy_mmio_uart.sv
// 16-byte MMIO window on the cozy_cpu memory port exposing an 8N1 UART.
// TX and RX each have a byte FIFO; reads are side-effect free so fetches can pass through the window.

module cozy_mmio_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the occupancy before the edge, so a push to a full FIFO is dropped even if a pop happens too.
    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module cozy_mmio_uart #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr,
    input  logic [1:0]  mem_bwe,
    input  logic [15:0] mem_dout,
    output logic [15:0] mem_din,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic        hit;
    logic [2:0]  off;
    logic        tx_push, ctrl_wr, status_w1c, tx_flush, rx_pop, rx_flush;
    logic [15:0] divisor, div_eff;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]  tx_head, rx_head;
    logic        tx_nonempty, tx_full, rx_nonempty, rx_full;
    logic        rx_overrun, rx_frame_err, tx_overflow;
    logic        tx_pop, tx_bit_end;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_end, rx_push, rx_ferr_set;
    logic [15:0] rd_word;

    assign hit        = mem_addr[15:4] == BASE_ADDR[15:4];
    assign off        = mem_addr[3:1];
    assign tx_push    = hit && mem_bwe[0] && off == 3'd0;
    assign ctrl_wr    = hit && mem_bwe[0] && off == 3'd2;
    assign status_w1c = hit && mem_bwe[1] && off == 3'd1;
    assign tx_flush   = ctrl_wr && mem_dout[1];
    assign rx_pop     = ctrl_wr && mem_dout[0];
    assign rx_flush   = ctrl_wr && mem_dout[2];
    assign div_eff    = (divisor < 16'd2) ? 16'd2 : divisor;

    assign tx_nonempty = tx_count != '0;
    assign tx_full     = tx_count == CW'(FIFO_DEPTH);
    assign rx_nonempty = rx_count != '0;
    assign rx_full     = rx_count == CW'(FIFO_DEPTH);

    cozy_mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(mem_dout[7:0]), .head(tx_head), .count(tx_count)
    );

    cozy_mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_shift), .head(rx_head), .count(rx_count)
    );

    // The head is popped in the same cycle a frame starts, including back-to-back from STOP.
    assign tx_bit_end = tx_cnt == tx_div;
    assign tx_pop     = tx_nonempty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_end));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        uart_txd <= 1'b0;
                        tx_shift <= tx_head;
                        tx_div   <= div_eff;
                        tx_cnt   <= '0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        uart_txd <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            uart_txd <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            uart_txd <= 1'b0;
                            tx_shift <= tx_head;
                            tx_div   <= div_eff;
                        end else tx_state <= TX_IDLE;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
            endcase
        end
    end

    assign rx_stop_end = rx_state == RX_STOP && rx_cnt == rx_div;
    assign rx_push     = rx_stop_end && rx_s2;
    assign rx_ferr_set = rx_stop_end && !rx_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_div   <= div_eff;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Half-bit recheck rejects glitches and aligns later samples to bit centres.
                    if (rx_cnt == (rx_div >> 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                RX_DATA: begin
                    if (rx_cnt == rx_div) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                RX_STOP: begin
                    if (rx_stop_end) rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
                    else rx_cnt <= rx_cnt + 16'd1;
                end
                default: begin
                    if (rx_s2) rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            divisor      <= DEFAULT_DIV;
        end else begin
            rx_overrun   <= (rx_push && rx_full) || (rx_overrun && !(status_w1c && mem_dout[8]));
            rx_frame_err <= rx_ferr_set || (rx_frame_err && !(status_w1c && mem_dout[9]));
            tx_overflow  <= (tx_push && tx_full) || (tx_overflow && !(status_w1c && mem_dout[10]));
            if (hit && off == 3'd3 && mem_bwe[0]) divisor[7:0]  <= mem_dout[7:0];
            if (hit && off == 3'd3 && mem_bwe[1]) divisor[15:8] <= mem_dout[15:8];
        end
    end

    always_comb begin
        rd_word = 16'h0000;
        case (off)
            3'd0: rd_word = {rx_nonempty, 7'b0, rx_nonempty ? rx_head : 8'h00};
            3'd1: rd_word = {5'b0, tx_overflow, rx_frame_err, rx_overrun, 3'b0,
                             tx_state != TX_IDLE, tx_full, !tx_nonempty, rx_full, rx_nonempty};
            3'd3: rd_word = divisor;
            default: rd_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mem_din <= 16'h0000;
        else if (!hit) mem_din <= 16'h0000;
        else if (mem_addr[0]) mem_din <= {8'h00, rd_word[15:8]};
        else mem_din <= rd_word;
    end
endmodule
